// File: rtl/bfm_req_arbiter.sv
// Round-robin arbiter sharing one downstream req/ack responder among N_REQ requesters.
// Optional per-requester completion counters (xfer_cnt_o) are enabled by defining BFM_ARB_STATS_EN.
module bfm_req_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic                        req_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  input  logic                        ack_i,
  output logic                        busy_o,
  output logic [IDX_W-1:0]            grant_idx_o
`ifdef BFM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         xfer_cnt_o
`endif
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;

  logic [DATA_WIDTH-1:0] data_arr [N_REQ];
  logic                  any_req;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand;
  logic                  owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  complete;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % N_REQ);
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign owner_req  = req_i[owner_q];
  assign owner_data = data_arr[owner_q];

  // GRANT always falls back to IDLE so a lagging ack cannot reach the next owner.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    complete     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = winner;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end else if (ack_i) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          complete     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // An ack is only forwarded while the owner's request is actually presented downstream.
  always_comb begin
    req_o  = 1'b0;
    data_o = '0;
    ack_o  = '0;
    if (state_q == GRANT) begin
      req_o          = owner_req;
      data_o         = owner_data;
      ack_o[owner_q] = ack_i & owner_req;
    end
  end

  assign busy_o      = (state_q == GRANT);
  assign grant_idx_o = owner_q;

`ifdef BFM_ARB_STATS_EN
  logic [15:0] xfer_cnt_q [N_REQ];
  logic [15:0] xfer_cnt_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      xfer_cnt_d[i] = xfer_cnt_q[i];
      if (complete && (owner_q == IDX_W'(i))) begin
        xfer_cnt_d[i] = xfer_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        xfer_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        xfer_cnt_q[i] <= xfer_cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      xfer_cnt_o[i*16 +: 16] = xfer_cnt_q[i];
    end
  end
`endif

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_o));

endmodule

// File: doc/bfm_req_arbiter.md
Name: bfm_req_arbiter

Overview:
- Round-robin arbiter that lets N_REQ simple_bfm-style requesters (req/ack/data, 8-bit) share one downstream req/ack responder.
- Sits between the BFM instances and the single ack-generating sink in a unit-test top.
- Grants one requester at a time, muxes its data and request downstream, and routes the returned ack back to that requester only.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..16
- DATA_WIDTH, 8, data bits per requester
- IDX_W, $clog2(N_REQ), width of grant index (derived; do not override)

Ports:
- clk  input  1  single clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- req_i  input  N_REQ  per-requester request; held high until the ack handshake
- data_i  input  N_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ack_o  output  N_REQ  per-requester ack; only the granted bit can be high
- req_o  output  1  downstream request
- data_o  output  DATA_WIDTH  downstream data
- ack_i  input  1  downstream ack
- busy_o  output  1  high while in GRANT
- grant_idx_o  output  IDX_W  current or last owner index

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, owner = 0, last_grant = N_REQ-1, so requester 0 wins first.
  - Outputs: req_o=0, data_o=0, ack_o=0, busy_o=0, grant_idx_o=0.
- States:
  - IDLE: no owner. req_o=0, data_o=0, ack_o=0. ack_i is ignored.
  - GRANT: owner is locked.
- IDLE -> GRANT: on a posedge with any req_i bit high.
  - Winner = first set bit scanning last_grant+1, last_grant+2, ... modulo N_REQ.
  - owner and grant_idx_o load the winner at that edge.
- In GRANT (combinational from registered owner):
  - req_o = req_i[owner]
  - data_o = data_i slice of owner
  - ack_o[owner] = ack_i; all other ack_o bits = 0
  - busy_o = 1
- GRANT -> IDLE, completion: on the posedge where req_o && ack_i. last_grant <= owner.
- GRANT -> IDLE, abandon: on a posedge where req_i[owner]==0. last_grant <= owner; no transfer is counted.
- Mandatory dead cycle:
  - At least one IDLE cycle between consecutive grants; there is no GRANT -> GRANT transition.
  - Reason: the downstream responder's ack lags req by one cycle. Without the dead cycle, a stale ack would complete the next owner's transfer falsely.
- Latency:
  - req_i rising at edge k appears on req_o from edge k+1 at the earliest.
  - Per-requester throughput is at most one transfer per 3 cycles when the sink acks after 1 cycle.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- Simultaneous events:
  - A new req_i arriving during GRANT waits; it is not pre-empted.
  - ack_i high while req_o low has no effect.
- Reset mid-transfer: all state clears immediately and ack_o drops asynchronously. The requester sees no completion.
- grant_idx_o holds the last owner while IDLE; it is not cleared after completion.

Optional Feature:
- Macro: BFM_ARB_STATS_EN
- Defined:
  - Adds output xfer_cnt_o, N_REQ*16 bits, packed like data_i.
  - Counter i increments on each completion by requester i; abandons do not count.
  - Counters wrap 16'hFFFF -> 0 and reset to 0.
- Not defined: the port and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, N_REQ=2, req_i=2'b01, data_i[7:0]=8'hA5, sink acks req delayed 1 cycle:
  - grant at edge 1; req_o=1 and data_o=8'hA5 at edge 1..2; ack_o=2'b01 in cycle 2.
  - IDLE at edge 2; busy_o=0 for exactly 1 cycle.
- Both req high continuously, data 8'h11/8'h22:
  - downstream data sequence 11,22,11,22.
  - no ack_o pulse is ever observed while req_o=0 (no double-counted ack).
- Requester 1 drops req_i[1] one cycle after grant, before ack_i:
  - return to IDLE, ack_o[1] never high.
  - next grant goes to requester 0 if pending.
- Assert rst_n=0 mid-GRANT with ack_i=1:
  - ack_o=0, req_o=0 immediately (asynchronous).
  - after release, requester 0 gets first grant even if requester 1 owned before.
- N_REQ=4, req_i=4'b1010 after last_grant=3: grant order 1,3,1,3.
- With BFM_ARB_STATS_EN, 70000 completions by requester 0: xfer_cnt_o[15:0] = 70000 mod 65536 = 4464; abandons add 0.
